// File: rtl/dma_pkg.sv
// Shared definitions for the OAM DMA engine: FSM states and the default OAM
// destination window.
package dma_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StDrain
    } dma_state_e;

    localparam logic [15:0] OAM_BASE = 16'hFE00;
    localparam int unsigned OAM_LEN  = 160;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies LENGTH bytes from {page, 8'h00} to DEST_BASE, one
// byte per cycle, through a registered-read memory port.
module oam_dma
    import dma_pkg::*;
#(
    parameter int unsigned LENGTH    = OAM_LEN,
    parameter logic [15:0] DEST_BASE = OAM_BASE
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_src_page,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_mem_rd_addr,
    input  logic [7:0]  i_mem_rd_data,
    output logic        o_mem_wr_en,
    output logic [15:0] o_mem_wr_addr,
    output logic [7:0]  o_mem_wr_data
);

    localparam logic [7:0] LastIdx = 8'(LENGTH - 1);

    dma_state_e state_q;
    logic [7:0] page_q;
    logic [7:0] rd_idx_q;
    logic [7:0] wr_idx_q;
    logic       pend_q;
    logic       done_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            page_q   <= 8'h00;
            rd_idx_q <= 8'h00;
            wr_idx_q <= 8'h00;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            pend_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        page_q   <= i_src_page;
                        rd_idx_q <= 8'h00;
                        state_q  <= StXfer;
                    end
                end
                StXfer: begin
                    // The read issued this cycle returns next cycle, so it becomes the pending write.
                    pend_q   <= 1'b1;
                    wr_idx_q <= rd_idx_q;
                    rd_idx_q <= rd_idx_q + 8'h01;
                    if (rd_idx_q == LastIdx) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    state_q <= StIdle;
                    done_q  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_busy        = (state_q != StIdle);
        o_done        = done_q;
        o_mem_rd_addr = 16'h0000;
        if (state_q == StXfer) begin
            o_mem_rd_addr = {page_q, 8'h00} + {8'h00, rd_idx_q};
        end
        o_mem_wr_en   = pend_q;
        o_mem_wr_addr = 16'h0000;
        o_mem_wr_data = 8'h00;
        if (pend_q) begin
            o_mem_wr_addr = DEST_BASE + {8'h00, wr_idx_q};
            o_mem_wr_data = i_mem_rd_data;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: random memory images copied through the DUT and compared
// against a whole-memory copy model, plus cycle, reset and LENGTH=1 checks.
module tb_oam_dma;
    import dma_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_src_page = 8'h00;
    logic        busy, done, wr_en;
    logic [15:0] rd_addr, wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  mem_rd_data = 8'h00;

    logic        start1 = 1'b0;
    logic [7:0]  page1 = 8'h00;
    logic        busy1, done1, wr_en1;
    logic [15:0] rd_addr1, wr_addr1;
    logic [7:0]  wr_data1;
    logic [7:0]  rd_data1 = 8'h00;

    int total = 0;
    int bad = 0;

    always #5 i_clk = ~i_clk;

    oam_dma dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_src_page(i_src_page),
        .o_busy(busy), .o_done(done), .o_mem_rd_addr(rd_addr), .i_mem_rd_data(mem_rd_data),
        .o_mem_wr_en(wr_en), .o_mem_wr_addr(wr_addr), .o_mem_wr_data(wr_data)
    );

    oam_dma #(.LENGTH(1)) dut1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(start1), .i_src_page(page1),
        .o_busy(busy1), .o_done(done1), .o_mem_rd_addr(rd_addr1), .i_mem_rd_data(rd_data1),
        .o_mem_wr_en(wr_en1), .o_mem_wr_addr(wr_addr1), .o_mem_wr_data(wr_data1)
    );

    // Memory environment with registered read; reload copies the initial image in one cycle.
    logic [7:0] mem      [0:65535];
    logic [7:0] init_mem [0:65535];
    logic [7:0] ref_mem  [0:65535];
    logic       reload = 1'b0;

    always @(posedge i_clk) begin
        if (reload) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_mem[i];
        end else begin
            mem_rd_data <= mem[rd_addr];
            if (wr_en) mem[wr_addr] <= wr_data;
        end
        rd_data1 <= rd_addr1[15:8] ^ 8'h5A;
    end

    // Cumulative activity monitors; tests diff snapshots around each transfer.
    int busy_cyc = 0, wr_tot = 0, done_tot = 0, page_err = 0, order_err = 0, idle_err = 0;
    int busy1_cyc = 0, wr1_tot = 0, done1_tot = 0;
    logic [15:0] wr1_addr_seen = 16'h0;
    logic [7:0]  wr1_data_seen = 8'h0;
    logic [15:0] last_rd = 16'h0;
    logic [7:0]  exp_page = 8'h00;

    always @(posedge i_clk) begin
        last_rd <= rd_addr;
        if (busy) busy_cyc++;
        if (done) done_tot++;
        if (busy && rd_addr != 16'h0 && rd_addr[15:8] != exp_page) page_err++;
        if (wr_en) begin
            wr_tot++;
            if (last_rd[15:8] != exp_page || wr_addr != 16'hFE00 + {8'h00, last_rd[7:0]})
                order_err++;
        end else if (wr_addr != 16'h0 || wr_data != 8'h0) begin
            idle_err++;
        end
        if (busy1) busy1_cyc++;
        if (done1) done1_tot++;
        if (wr_en1) begin
            wr1_tot++;
            wr1_addr_seen <= wr_addr1;
            wr1_data_seen <= wr_data1;
        end
    end

    task automatic fill_random();
        for (int i = 0; i < 65536; i++) init_mem[i] = 8'($urandom);
    endtask

    task automatic sync_ref_and_load();
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_mem[i];
        @(negedge i_clk);
        reload = 1'b1;
        @(negedge i_clk);
        reload = 1'b0;
    endtask

    // Copy semantics: all source bytes are taken before any destination byte changes.
    task automatic model_copy(input logic [7:0] page, input int len);
        logic [7:0] src [256];
        for (int k = 0; k < len; k++) src[k] = ref_mem[{page, 8'h00} + 16'(k)];
        for (int k = 0; k < len; k++) ref_mem[16'hFE00 + 16'(k)] = src[k];
    endtask

    function automatic int mem_diff(output int first);
        int n = 0;
        first = -1;
        for (int i = 0; i < 65536; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                if (first < 0) first = i;
                n++;
            end
        end
        return n;
    endfunction

    task automatic start_xfer(input logic [7:0] page);
        @(negedge i_clk);
        i_src_page = page;
        i_start    = 1'b1;
        @(negedge i_clk);
        i_start    = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge i_clk);
            if ((which ? done1 : done) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_busy_done: got busy=%b done=%b want 0 0", busy, done);
        end
        total++; if (wr_en !== 1'b0 || wr_addr !== 16'h0 || wr_data !== 8'h0) begin
            bad++; $display("FAIL reset_wr: got en=%b addr=%h data=%h want zeros", wr_en, wr_addr, wr_data);
        end
        total++; if (rd_addr !== 16'h0) begin
            bad++; $display("FAIL reset_rd: got %h want 0000", rd_addr);
        end
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        total++; if (busy !== 1'b0 || wr_en !== 1'b0 || rd_addr !== 16'h0) begin
            bad++; $display("FAIL idle_after_reset: busy=%b wr_en=%b rd=%h", busy, wr_en, rd_addr);
        end
    endtask

    task automatic test_basic();
        int b0, w0, d0, p0, o0, i0, nd, first;
        bit ok;
        fill_random();
        for (int k = 0; k < 160; k++) init_mem[16'hC000 + 16'(k)] = 8'(k);
        sync_ref_and_load();
        model_copy(8'hC0, 160);
        exp_page = 8'hC0;
        b0 = busy_cyc; w0 = wr_tot; d0 = done_tot; p0 = page_err; o0 = order_err; i0 = idle_err;
        start_xfer(8'hC0);
        wait_done(1'b0, 400, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout: no done within 400 cycles"); end
        @(negedge i_clk);
        total++; if (busy_cyc - b0 != 161) begin
            bad++; $display("FAIL basic_busy_cycles: got %0d want 161", busy_cyc - b0);
        end
        total++; if (wr_tot - w0 != 160) begin
            bad++; $display("FAIL basic_writes: got %0d want 160", wr_tot - w0);
        end
        total++; if (done_tot - d0 != 1) begin
            bad++; $display("FAIL basic_done_pulses: got %0d want 1", done_tot - d0);
        end
        total++; if (page_err - p0 != 0 || order_err - o0 != 0 || idle_err - i0 != 0) begin
            bad++; $display("FAIL basic_addr_order: page_err=%0d order_err=%0d idle_err=%0d want 0",
                            page_err - p0, order_err - o0, idle_err - i0);
        end
        nd = mem_diff(first);
        total++; if (nd != 0) begin
            bad++; $display("FAIL basic_mem: %0d bytes differ, first at %h got %h want %h",
                            nd, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic test_cycle();
        int nd, first;
        fill_random();
        sync_ref_and_load();
        model_copy(8'hC0, 160);
        exp_page = 8'hC0;
        start_xfer(8'hC0);
        total++; if (rd_addr !== 16'hC000 || wr_en !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL cyc_e0: rd=%h wr_en=%b busy=%b want C000 0 1", rd_addr, wr_en, busy);
        end
        @(negedge i_clk);
        total++; if (wr_en !== 1'b1 || wr_addr !== 16'hFE00 || rd_addr !== 16'hC001) begin
            bad++; $display("FAIL cyc_e1: wr_en=%b wr=%h rd=%h want 1 FE00 C001", wr_en, wr_addr, rd_addr);
        end
        total++; if (wr_data !== init_mem[16'hC000]) begin
            bad++; $display("FAIL cyc_e1_data: got %h want %h", wr_data, init_mem[16'hC000]);
        end
        repeat (159) @(negedge i_clk);
        total++; if (wr_en !== 1'b1 || wr_addr !== 16'hFE9F || wr_data !== init_mem[16'hC09F]) begin
            bad++; $display("FAIL cyc_e160: en=%b wr=%h data=%h want 1 FE9F %h",
                            wr_en, wr_addr, wr_data, init_mem[16'hC09F]);
        end
        @(negedge i_clk);
        total++; if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
            bad++; $display("FAIL cyc_done: done=%b busy=%b wr_en=%b want 1 0 0", done, busy, wr_en);
        end
        @(negedge i_clk);
        total++; if (done !== 1'b0) begin
            bad++; $display("FAIL cyc_done_width: done=%b want 0", done);
        end
        nd = mem_diff(first);
        total++; if (nd != 0) begin
            bad++; $display("FAIL cyc_mem: %0d bytes differ, first at %h", nd, first);
        end
    endtask

    task automatic test_ignore_start();
        int b0, w0, p0, nd, first;
        bit ok;
        fill_random();
        sync_ref_and_load();
        model_copy(8'hC0, 160);
        exp_page = 8'hC0;
        b0 = busy_cyc; w0 = wr_tot; p0 = page_err;
        start_xfer(8'hC0);
        repeat ($urandom_range(5, 140)) @(negedge i_clk);
        i_src_page = 8'h80;
        i_start    = 1'b1;
        @(negedge i_clk);
        i_start    = 1'b0;
        wait_done(1'b0, 400, ok);
        total++; if (!ok) begin bad++; $display("FAIL ign_timeout: no done within 400 cycles"); end
        @(negedge i_clk);
        total++; if (wr_tot - w0 != 160 || busy_cyc - b0 != 161) begin
            bad++; $display("FAIL ign_counts: writes=%0d busy=%0d want 160 161",
                            wr_tot - w0, busy_cyc - b0);
        end
        total++; if (page_err - p0 != 0) begin
            bad++; $display("FAIL ign_src_page: %0d reads outside page C0, want 0", page_err - p0);
        end
        nd = mem_diff(first);
        total++; if (nd != 0) begin
            bad++; $display("FAIL ign_mem: %0d bytes differ, first at %h", nd, first);
        end
    endtask

    task automatic test_reset_mid();
        int w0, d0, nd, first, n;
        logic [7:0] page;
        bit ok;
        fill_random();
        sync_ref_and_load();
        model_copy(8'hC0, 50);
        exp_page = 8'hC0;
        w0 = wr_tot; d0 = done_tot;
        start_xfer(8'hC0);
        n = 0;
        while (wr_tot - w0 < 50 && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        total++; if (wr_tot - w0 != 50 || busy !== 1'b1) begin
            bad++; $display("FAIL rst_mid_reach: writes=%0d busy=%b want 50 1", wr_tot - w0, busy);
        end
        i_rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 16'h0 || wr_data !== 8'h0 ||
                     rd_addr !== 16'h0 || done !== 1'b0) begin
            bad++; $display("FAIL rst_mid_async: busy=%b en=%b wa=%h wd=%h rd=%h done=%b want zeros",
                            busy, wr_en, wr_addr, wr_data, rd_addr, done);
        end
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        total++; if (wr_tot - w0 != 50 || done_tot - d0 != 0) begin
            bad++; $display("FAIL rst_mid_abort: writes=%0d done=%0d want 50 0",
                            wr_tot - w0, done_tot - d0);
        end
        nd = mem_diff(first);
        total++; if (nd != 0) begin
            bad++; $display("FAIL rst_mid_mem: %0d bytes differ, first at %h", nd, first);
        end
        page = 8'($urandom_range(0, 253));
        model_copy(page, 160);
        exp_page = page;
        d0 = done_tot;
        start_xfer(page);
        wait_done(1'b0, 400, ok);
        @(negedge i_clk);
        total++; if (!ok || done_tot - d0 != 1) begin
            bad++; $display("FAIL rst_restart: ok=%b done=%0d want 1 1", ok, done_tot - d0);
        end
        nd = mem_diff(first);
        total++; if (nd != 0) begin
            bad++; $display("FAIL rst_restart_mem: %0d bytes differ, first at %h", nd, first);
        end
    endtask

    task automatic test_back_to_back();
        int b0, w0, d0, o0, nd, first;
        bit ok;
        fill_random();
        for (int k = 0; k < 160; k++) init_mem[16'hFE00 + 16'(k)] = 8'(8'hA0 + k);
        sync_ref_and_load();
        model_copy(8'hFE, 160);
        model_copy(8'hFE, 160);
        exp_page = 8'hFE;
        b0 = busy_cyc; w0 = wr_tot; d0 = done_tot; o0 = order_err;
        start_xfer(8'hFE);
        wait_done(1'b0, 400, ok);
        i_src_page = 8'hFE;
        i_start    = 1'b1;
        @(negedge i_clk);
        i_start    = 1'b0;
        total++; if (!ok || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_restart: ok=%b busy=%b want 1 1", ok, busy);
        end
        wait_done(1'b0, 400, ok);
        @(negedge i_clk);
        total++; if (!ok || done_tot - d0 != 2 || wr_tot - w0 != 320 || busy_cyc - b0 != 322) begin
            bad++; $display("FAIL b2b_counts: ok=%b done=%0d writes=%0d busy=%0d want 1 2 320 322",
                            ok, done_tot - d0, wr_tot - w0, busy_cyc - b0);
        end
        total++; if (order_err - o0 != 0) begin
            bad++; $display("FAIL b2b_order: %0d misordered writes, want 0", order_err - o0);
        end
        nd = mem_diff(first);
        total++; if (nd != 0) begin
            bad++; $display("FAIL b2b_mem: %0d bytes differ, first at %h", nd, first);
        end
    endtask

    task automatic test_len1();
        int b0, w0, d0;
        logic [7:0] page;
        bit ok;
        page = 8'($urandom);
        b0 = busy1_cyc; w0 = wr1_tot; d0 = done1_tot;
        @(negedge i_clk);
        page1  = page;
        start1 = 1'b1;
        @(negedge i_clk);
        start1 = 1'b0;
        wait_done(1'b1, 20, ok);
        total++; if (!ok || busy1 !== 1'b0) begin
            bad++; $display("FAIL len1_done: ok=%b busy=%b want 1 0", ok, busy1);
        end
        @(negedge i_clk);
        total++; if (busy1_cyc - b0 != 2 || wr1_tot - w0 != 1 || done1_tot - d0 != 1) begin
            bad++; $display("FAIL len1_counts: busy=%0d writes=%0d done=%0d want 2 1 1",
                            busy1_cyc - b0, wr1_tot - w0, done1_tot - d0);
        end
        total++; if (wr1_addr_seen !== 16'hFE00 || wr1_data_seen !== (page ^ 8'h5A)) begin
            bad++; $display("FAIL len1_write: addr=%h data=%h want FE00 %h",
                            wr1_addr_seen, wr1_data_seen, page ^ 8'h5A);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cycle();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_len1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The block SHALL take parameter LENGTH, default 160, giving the bytes copied per transfer (legal range 1..256).
REQ-002 The block SHALL take parameter DEST_BASE, default 16'hFE00, giving the first destination address.
REQ-003 Clock i_clk; reset i_rst, asynchronous, active-high.
REQ-004 i_clk  input  1  rising-edge clock.
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_start  input  1  transfer request, sampled on the rising edge.
REQ-007 i_src_page  input  8  source high byte; the source base is {i_src_page, 8'h00}.
REQ-008 o_busy  output  1  high while the transfer owns the memory port.
REQ-009 o_done  output  1  one-cycle completion pulse.
REQ-010 o_mem_rd_addr  output  16  read address to the memory.
REQ-011 i_mem_rd_data  input  8  registered memory read data, available one cycle after the address.
REQ-012 o_mem_wr_en, o_mem_wr_addr[15:0], o_mem_wr_data[7:0]  outputs  memory write port.

Function
REQ-013 The FSM SHALL have exactly three states:
- IDLE
- XFER
- DRAIN
REQ-014 In IDLE, i_start=1 at an edge SHALL do all of the following:
- latch i_src_page;
- clear the read index to 0;
- enter XFER.
REQ-015 In XFER, o_mem_rd_addr SHALL equal {page,8'h00} + read index, with an 8-bit index that does not wrap into the next page.
REQ-016 Each XFER edge SHALL increment the read index and set a one-deep pending flag whose write index equals the read index just issued.
REQ-017 In any cycle with the pending flag set, the block SHALL assert o_mem_wr_en=1, with:
- o_mem_wr_addr = DEST_BASE + write index;
- o_mem_wr_data = i_mem_rd_data, passed through unregistered.
REQ-018 The block SHALL leave XFER for DRAIN on the edge that issues read index LENGTH-1.
REQ-019 DRAIN SHALL last one cycle, write the final byte, then return to IDLE.
REQ-020 o_done SHALL be registered and high for exactly the one cycle after DRAIN, while o_busy is 0.
REQ-021 o_busy SHALL be 1 in XFER and DRAIN; a transfer SHALL hold o_busy for LENGTH+1 cycles and issue exactly LENGTH writes.
REQ-022 The write to DEST_BASE+k SHALL occur in the cycle immediately after read address base+k is presented; there SHALL be no gaps or stalls.
REQ-023 i_start SHALL be ignored while o_busy=1.
REQ-024 i_start SHALL be accepted in the o_done cycle, starting the next transfer back-to-back.
REQ-025 When not writing, o_mem_wr_en SHALL be 0, o_mem_wr_addr 16'h0000 and o_mem_wr_data 8'h00.
REQ-026 In IDLE, o_mem_rd_addr SHALL be 16'h0000.
REQ-027 Source and destination SHALL be allowed to overlap, including page FE:
- read and write addresses in the same cycle always differ by a fixed offset;
- no hazard handling is required.
REQ-028 Echo-region (E0..FF) source remapping is out of scope; addresses SHALL be emitted literally.

Reset
REQ-029 i_rst SHALL force the following immediately, independent of the clock:
- state to IDLE;
- index and pending flag to 0;
- o_busy, o_done and o_mem_wr_en to 0;
- the address/data outputs to 0.
REQ-030 Reset mid-transfer SHALL abort with no further writes and no o_done pulse; the latched page SHALL be discarded.

Structure
REQ-031 A shared package dma_pkg SHALL hold:
- the state enum (IDLE, XFER, DRAIN);
- constant OAM_BASE = 16'hFE00;
- constant OAM_LEN = 160.
REQ-032 The block SHALL be a single module with no sub-module; the top level SHALL mux memory address/write ports to oam_dma when o_busy=1.

Verification
REQ-033 Start with page 8'hC0, memory preloaded C000+k = k: the bench SHALL check each of the following.
- FE00..FE9F = 00..9F;
- o_busy high for exactly 161 cycles;
- o_done pulses once;
- 160 writes in total.
REQ-034 Cycle check, start at edge E0:
- cycle after E0: rd_addr = C000, wr_en = 0;
- cycle after E1: wr_addr = FE00, rd_addr = C001;
- cycle after E160: wr_addr = FE9F.
REQ-035 Pulse i_start mid-transfer with page 8'h80: ignored, all source reads stay C0xx, and the write count is 160.
REQ-036 Assert i_rst after 50 writes: FE32..FE9F are unchanged, outputs are 0 asynchronously, and o_done never pulses; a new start afterwards completes normally.
REQ-037 Back-to-back start in the o_done cycle with page 8'hFE, FE00+k preset = 8'hA0+k: the second copy completes with o_busy high again on the next cycle.
REQ-038 Parameter LENGTH=1: o_busy is high for 2 cycles, exactly one write to DEST_BASE, then the o_done pulse.
